// File: rtl/retinex_he_frame_ctrl.sv
// Frame sequencer for the Retinex/HE luminance path: pixel position tracking,
// one-frame histogram gating, CDF/LUT build, LUT swap, histogram clear, output markers.
module retinex_he_frame_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int Y_LAT    = 3,
    parameter int PIPE_LAT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pixel_valid_in,
    input  logic       frame_start,
    output logic [9:0] x_cnt,
    output logic [9:0] y_cnt,
    output logic       hist_acc_en,
    output logic       cdf_en,
    output logic       clr_en,
    output logic [7:0] bin_addr,
    output logic       lut_swap,
    output logic       valid_out,
    output logic       sof_out,
    output logic       eof_out,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ACCUM = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CDF   = 3'd4,
        ST_SWAP  = 3'd5
    } state_t;

    localparam int         DW         = (Y_LAT > 1) ? $clog2(Y_LAT) : 1;
    localparam logic [9:0] X_LAST     = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST     = 10'(V_ACTIVE - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(Y_LAT - 1);

    state_t              state_r, state_nxt_s;
    logic [9:0]          x_r, y_r, x_nxt_s, y_nxt_s;
    logic [7:0]          bin_r, bin_nxt_s;
    logic [DW-1:0]       drain_r, drain_nxt_s;
    logic                accept_s, first_s, last_s, overrun_set_s;
    logic                overrun_r;
    logic [Y_LAT-1:0]    acc_dly_r;
    logic [PIPE_LAT-1:0] vld_dly_r, sof_dly_r, eof_dly_r;

    // A frame_start in IDLE with a pixel makes that pixel (0,0) of the new frame.
    assign accept_s      = pixel_valid_in &&
                           ((state_r == ST_ACCUM) || ((state_r == ST_IDLE) && frame_start));
    assign first_s       = accept_s && (x_r == 10'd0) && (y_r == 10'd0);
    assign last_s        = accept_s && (x_r == X_LAST) && (y_r == Y_LAST);
    assign overrun_set_s = (pixel_valid_in && !accept_s) ||
                           (frame_start && (state_r != ST_IDLE));

    // Next-state and counter update logic.
    always_comb begin
        state_nxt_s = state_r;
        x_nxt_s     = x_r;
        y_nxt_s     = y_r;
        bin_nxt_s   = bin_r;
        drain_nxt_s = drain_r;
        if (accept_s) begin
            if (x_r == X_LAST) begin
                x_nxt_s = 10'd0;
                y_nxt_s = (y_r == Y_LAST) ? 10'd0 : (y_r + 10'd1);
            end else begin
                x_nxt_s = x_r + 10'd1;
            end
        end else begin
            x_nxt_s = x_r;
        end
        case (state_r)
            ST_CLEAR: begin
                if (bin_r == 8'd255) begin
                    state_nxt_s = ST_IDLE;
                    bin_nxt_s   = 8'd0;
                end else begin
                    bin_nxt_s = bin_r + 8'd1;
                end
            end
            ST_IDLE: begin
                if (frame_start) begin
                    state_nxt_s = last_s ? ST_DRAIN : ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                // Hold off the CDF sweep until the last histogram increment lands.
                if (drain_r == DRAIN_LAST) begin
                    state_nxt_s = ST_CDF;
                    drain_nxt_s = '0;
                end else begin
                    drain_nxt_s = drain_r + DW'(1);
                end
            end
            ST_CDF: begin
                if (bin_r == 8'd255) begin
                    state_nxt_s = ST_SWAP;
                    bin_nxt_s   = 8'd0;
                end else begin
                    bin_nxt_s = bin_r + 8'd1;
                end
            end
            ST_SWAP: begin
                state_nxt_s = ST_CLEAR;
            end
            default: begin
                state_nxt_s = ST_CLEAR;
                bin_nxt_s   = 8'd0;
            end
        endcase
    end

    // State, counters and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_CLEAR;
            x_r       <= 10'd0;
            y_r       <= 10'd0;
            bin_r     <= 8'd0;
            drain_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            x_r       <= x_nxt_s;
            y_r       <= y_nxt_s;
            bin_r     <= bin_nxt_s;
            drain_r   <= drain_nxt_s;
            overrun_r <= overrun_r | overrun_set_s;
        end
    end

    // Latency-matching delay lines for histogram enable and output markers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_dly_r <= '0;
            vld_dly_r <= '0;
            sof_dly_r <= '0;
            eof_dly_r <= '0;
        end else begin
            acc_dly_r[0] <= accept_s;
            vld_dly_r[0] <= pixel_valid_in;
            sof_dly_r[0] <= first_s;
            eof_dly_r[0] <= last_s;
            for (int i = 1; i < Y_LAT; i++) begin
                acc_dly_r[i] <= acc_dly_r[i-1];
            end
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_dly_r[i] <= vld_dly_r[i-1];
                sof_dly_r[i] <= sof_dly_r[i-1];
                eof_dly_r[i] <= eof_dly_r[i-1];
            end
        end
    end

    assign x_cnt       = x_r;
    assign y_cnt       = y_r;
    assign bin_addr    = bin_r;
    assign clr_en      = (state_r == ST_CLEAR);
    assign cdf_en      = (state_r == ST_CDF);
    assign lut_swap    = (state_r == ST_SWAP);
    assign busy        = (state_r != ST_IDLE);
    assign overrun     = overrun_r;
    assign hist_acc_en = acc_dly_r[Y_LAT-1];
    assign valid_out   = vld_dly_r[PIPE_LAT-1];
    assign sof_out     = sof_dly_r[PIPE_LAT-1];
    assign eof_out     = eof_dly_r[PIPE_LAT-1];

endmodule

// File: tb/tb_retinex_he_frame_ctrl.sv
// Scoreboard bench for retinex_he_frame_ctrl on a 4x2 frame: the driver queues
// expected histogram/output events, a negedge monitor pops and compares them.
module tb_retinex_he_frame_ctrl;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int YL = 3;
    localparam int PL = 8;

    typedef struct packed {
        int   cyc;
        logic sof;
        logic eof;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n, pixel_valid_in, frame_start;
    logic [9:0] x_cnt, y_cnt;
    logic       hist_acc_en, cdf_en, clr_en, lut_swap;
    logic       valid_out, sof_out, eof_out, busy, overrun;
    logic [7:0] bin_addr;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  swaps = 0;
    int  hist_total = 0;
    int  hist_q[$];
    ev_t out_q[$];
    ev_t e;

    retinex_he_frame_ctrl #(
        .H_ACTIVE(H), .V_ACTIVE(V), .Y_LAT(YL), .PIPE_LAT(PL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pixel_valid_in(pixel_valid_in),
        .frame_start(frame_start), .x_cnt(x_cnt), .y_cnt(y_cnt),
        .hist_acc_en(hist_acc_en), .cdf_en(cdf_en), .clr_en(clr_en),
        .bin_addr(bin_addr), .lut_swap(lut_swap), .valid_out(valid_out),
        .sof_out(sof_out), .eof_out(eof_out), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_flags"},
            {clr_en, busy, cdf_en, lut_swap, hist_acc_en, valid_out, sof_out, eof_out, overrun},
            9'b110000000);
        chk({tag, "_cnt"}, {bin_addr, x_cnt, y_cnt}, 0);
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents an event.
    always @(negedge clk) begin
        if (hist_acc_en === 1'b1) begin
            hist_total++;
            chk("hist_expected", int'(hist_q.size() > 0), 1);
            if (hist_q.size() > 0) chk("hist_time", cyc, hist_q.pop_front());
            chk("hist_exclusive", {cdf_en, clr_en}, 0);
        end
        if (valid_out === 1'b1) begin
            chk("valid_expected", int'(out_q.size() > 0), 1);
            if (out_q.size() > 0) begin
                e = out_q.pop_front();
                chk("valid_time", cyc, e.cyc);
                chk("sof_out", sof_out, e.sof);
                chk("eof_out", eof_out, e.eof);
            end
        end
        if ((sof_out | eof_out) === 1'b1) chk("marker_gated", valid_out, 1);
        if (lut_swap === 1'b1) swaps++;
    end

    // Checks one 256-bin sweep, optionally injecting a stray pixel or aborting by reset.
    task automatic sweep(input bit cdf, input int inj, input int abort_at, output bit aborted);
        int bad = 0;
        aborted = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if (cdf) begin
                if (cdf_en !== 1'b1 || clr_en !== 1'b0) bad++;
            end else begin
                if (clr_en !== 1'b1 || cdf_en !== 1'b0) bad++;
            end
            if (bin_addr !== 8'(i) || lut_swap !== 1'b0 || busy !== 1'b1) bad++;
            if (i == abort_at) begin
                chk("cdf_partial", bad, 0);
                #2 rst_n = 1'b0;
                #1;
                chk_reset("abort_reset");
                aborted = 1'b1;
                return;
            end
            pixel_valid_in = (i == inj);
            if (i == inj) out_q.push_back('{cyc + PL, 1'b0, 1'b0});
            step();
        end
        pixel_valid_in = 1'b0;
        chk(cdf ? "cdf_sweep" : "clr_sweep", bad, 0);
    endtask

    // Drives one 4x2 frame; gap idle cycles between pixels, optional stray frame_start.
    task automatic frame(input bit arm, input int gap, input int fs_after);
        if (arm) begin
            frame_start = 1'b1;
            step();
            frame_start = 1'b0;
        end
        for (int n = 0; n < H * V; n++) begin
            chk("x_cnt", x_cnt, n % H);
            chk("y_cnt", y_cnt, n / H);
            pixel_valid_in = 1'b1;
            frame_start    = (n == 0) && !arm;
            hist_q.push_back(cyc + YL);
            out_q.push_back('{cyc + PL, (n == 0), (n == H * V - 1)});
            step();
            pixel_valid_in = 1'b0;
            frame_start    = 1'b0;
            if (n < H * V - 1) begin
                for (int g = 0; g < gap; g++) begin
                    frame_start = (g == 0) && (n == fs_after);
                    step();
                    frame_start = 1'b0;
                end
            end
        end
    endtask

    // Drain, CDF sweep, LUT swap and clear sweep following a frame.
    task automatic post(input int inj, input int abort_at);
        int bad = 0;
        bit ab;
        for (int k = 0; k < YL; k++) begin
            if (busy !== 1'b1 || cdf_en !== 1'b0 || clr_en !== 1'b0 ||
                x_cnt !== 10'd0 || y_cnt !== 10'd0) bad++;
            step();
        end
        chk("drain", bad, 0);
        sweep(1'b1, inj, abort_at, ab);
        if (ab) begin
            step();
            rst_n = 1'b1;
        end else begin
            chk("lut_swap_cycle", {lut_swap, cdf_en, busy}, 3'b101);
            step();
        end
        sweep(1'b0, -1, -1, ab);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        bit ab;
        rst_n          = 1'b1;
        pixel_valid_in = 1'b0;
        frame_start    = 1'b0;
        #1 rst_n = 1'b0;
        step();
        chk_reset("reset");
        rst_n = 1'b1;
        sweep(1'b0, -1, -1, ab);
        chk("idle_after_reset", {busy, clr_en}, 0);
        chk("overrun_init", overrun, 0);

        frame(1'b0, 0, -1);          // back-to-back pixels
        post(-1, -1);
        frame(1'b0, 1, -1);          // valid every other cycle
        post(-1, -1);
        chk("overrun_clean", overrun, 0);
        frame(1'b1, 0, -1);          // armed frame, stray pixel during CDF
        post(10, -1);
        chk("overrun_cdf_pixel", overrun, 1);
        frame(1'b0, 0, -1);          // reset at CDF bin 100
        post(-1, 100);
        chk("overrun_after_reset", overrun, 0);
        frame(1'b0, 1, 4);           // stray frame_start mid-frame
        chk("overrun_frame_start", overrun, 1);
        post(-1, -1);
        chk("overrun_sticky", overrun, 1);

        repeat (PL + 4) step();
        chk("hist_q_empty", hist_q.size(), 0);
        chk("out_q_empty", out_q.size(), 0);
        chk("hist_total", hist_total, 5 * H * V);
        chk("lut_swaps", swaps, 4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/retinex_he_frame_ctrl.md
Name: retinex_he_frame_ctrl

Overview:
- Frame-level sequencer for the Retinex/HE luminance pipeline.
- Tracks the active pixel position and gates histogram accumulation to exactly one frame.
- After the frame, runs the 256-bin CDF/LUT build, swaps the LUT, then clears the histogram RAM.
- Also generates the output valid/sof/eof markers, aligned to the pipeline latency.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
Y_LAT, 3, cycles from rgb_in acceptance to Y valid at the histogram input (delay for hist_acc_en)
PIPE_LAT, 8, cycles from rgb_in acceptance to rgb_out valid (delay for valid_out/sof_out/eof_out)

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
pixel_valid_in  in  1  input pixel strobe, same cycle as rgb_in
frame_start  in  1  one-cycle pulse marking the first pixel, or the pre-first-pixel arm, of a frame
x_cnt  out  10  column of the next pixel to accept
y_cnt  out  10  line of the next pixel to accept
hist_acc_en  out  1  histogram increment enable (Y-aligned)
cdf_en  out  1  CDF/LUT build step enable
clr_en  out  1  histogram clear write enable
bin_addr  out  8  bin index for cdf_en/clr_en sweeps
lut_swap  out  1  one-cycle pulse: new LUT becomes active
valid_out  out  1  delayed pixel strobe for rgb_out
sof_out  out  1  marks the first output pixel of an accepted frame
eof_out  out  1  marks the last output pixel of an accepted frame
busy  out  1  high in every state except IDLE
overrun  out  1  sticky error flag

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State is CLEAR, with bin counter = 0.
  - All outputs are 0, except busy=1 and clr_en=1 (Moore decodes of the reset state).
  - All delay lines are zeroed.
- Control outputs (cdf_en, clr_en, bin_addr, busy, x_cnt, y_cnt) are combinational decodes of registered state/counters only. There is no input-to-output combinational path.
- Accept rule: a pixel is accepted when pixel_valid_in=1 and either:
  - state=ACCUM, or
  - state=IDLE and frame_start=1 in the same cycle (that pixel is pixel (0,0)).
- States:
  - CLEAR: clr_en=1, bin_addr=bin counter, sweeping 0..255, one bin per cycle. After bin 255 -> IDLE.
  - IDLE: waits for frame_start. frame_start without pixel_valid_in -> ACCUM with x=y=0. frame_start with pixel_valid_in -> accept (0,0), go to ACCUM with x=1.
  - ACCUM: each accepted pixel increments x. At x=H_ACTIVE-1, x wraps to 0 and y increments. When pixel (H_ACTIVE-1, V_ACTIVE-1) is accepted -> DRAIN, and x/y return to 0.
  - DRAIN: lasts exactly Y_LAT cycles, so the last hist_acc_en pulse completes. Then -> CDF.
  - CDF: cdf_en=1 for 256 cycles, bin_addr 0..255. The cycle after bin 255, lut_swap=1 for one cycle and state -> CLEAR. cdf_en=0 in the lut_swap cycle.
- hist_acc_en: the accept signal delayed by Y_LAT registers. It is never high in the same cycle as cdf_en or clr_en.
- Output markers:
  - valid_out is pixel_valid_in delayed by PIPE_LAT cycles, regardless of state.
  - sof_out is accept-of-(0,0) delayed by PIPE_LAT.
  - eof_out is accept-of-last-pixel delayed by PIPE_LAT.
- Overrun: overrun is set by either:
  - pixel_valid_in=1 while the pixel is not accepted (IDLE without frame_start, DRAIN, CDF, CLEAR); the pixel is ignored for counting and histogram;
  - frame_start=1 in any state other than IDLE; it is ignored, and counters are unaffected.
- overrun is sticky and is cleared only by reset.
- Reset mid-operation: returns to CLEAR immediately. A partial histogram is therefore always wiped. No lut_swap is issued for an aborted frame.
- Minimum frame-to-frame gap after the last pixel: Y_LAT+256+1+256 cycles before the next frame_start.

Test Plan:
- Reset with H_ACTIVE=4, V_ACTIVE=2 -> clr_en=1, busy=1, bin_addr counts 0..255. IDLE (busy=0) is reached 256 cycles after rst_n rises.
- frame_start+valid, then 7 more valid in consecutive cycles -> hist_acc_en high 8 cycles, starting Y_LAT(3) cycles after the first pixel. DRAIN 3 cycles, cdf_en 256 cycles (bin 0..255), lut_swap one cycle, clr_en 256 cycles, then busy=0.
- Same frame with valid gaps (valid every other cycle) -> x_cnt sequence 0,1,2,3,0,1,2,3 against accepted pixels. y_cnt goes 0 then 1. Exactly 8 hist_acc_en pulses.
- valid_out/sof_out/eof_out -> each appears exactly PIPE_LAT(8) cycles after its input. sof_out is aligned with pixel (0,0) and eof_out with pixel (3,1).
- pixel_valid_in during CDF, and frame_start during ACCUM -> overrun=1 and stays 1. Histogram pulse count and x/y unchanged. Frame completes normally.
- rst_n asserted at CDF bin 100 -> all outputs go to reset values asynchronously. No lut_swap occurs. A full CLEAR sweep 0..255 follows reset release.
